decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32I decode pipeline stage; successor to the combinational Jala decoder.
//  Sits between fetch and register-read/execute; decodes all RV32I base opcodes.
//  Valid/ready handshake on both sides, optional skid entry for full throughput under backpressure.
//  Synchronous flush for branch/jump redirect; illegal-instruction flag for the trap path.
// PARAMETERS
//  PC_W     32  width of the PC carried alongside each instruction
//  SKID_EN  1   1: two-entry (output + skid) buffer, registered in_ready; 0: single entry, combinational in_ready
// PORTS
//  clk                    in   1     clock, rising edge
//  rst                    in   1     asynchronous reset, active-high
//  flush                  in   1     drop all buffered and incoming instructions
//  in_valid               in   1     fetch presents in_inst/in_pc
//  in_ready               out  1     stage accepts an instruction this cycle
//  in_inst                in   32    raw instruction
//  in_pc                  in   PC_W  PC of in_inst
//  out_valid              out  1     decoded bundle valid
//  out_ready              in   1     downstream accepts bundle
//  out_pc                 out  PC_W  PC of decoded instruction
//  out_rd/out_rs1/out_rs2 out  5     inst[11:7] / inst[19:15] / inst[24:20]
//  out_write_en           out  1     rd written (forced 0 if rd==0 or illegal)
//  out_immediate          out  32    selected immediate (I/S/B/U/J); 0 for R-type and illegal
//  out_alu_opcode         out  4     ALU op
//  out_alu_src2_from_imm  out  1     ALU src2 = immediate
//  out_alu_src1_from_pc   out  1     ALU src1 = PC (AUIPC, JAL, branch target)
//  out_lui_inst           out  1     LUI: result = immediate
//  out_mem_read/out_mem_write/out_branch/out_jump/out_illegal  out 1 each  class flags
// BEHAVIOUR
//  - Reset: out_valid=0, skid empty, all data outputs 0, in_ready=1 (SKID_EN=1).
//  - Accept = in_valid & in_ready; fire = out_valid & out_ready. Latency 1 cycle accept -> out_valid.
//  - Bundle outputs stay stable while out_valid & ~out_ready.
//  - ALU op: R-type {inst[30],funct3}; OP-IMM {inst[30],funct3} if funct3==101 else {0,funct3};
//    LUI/AUIPC/LOAD/STORE/JAL/JALR 4'h0; BRANCH 4'h8 (SUB). src2_from_imm=1 for all but R-type/BRANCH.
//  - Immediates: I for OP-IMM/LOAD/JALR, S STORE, B BRANCH, U LUI/AUIPC, J JAL; sign-extended to 32.
//  - out_jump=1 for JAL and JALR; JAL sets src1_from_pc, JALR does not.
//  - Illegal: unknown opcode; LOAD funct3 in {3,6,7}; STORE funct3>2; BRANCH funct3 in {2,3};
//    JALR funct3!=0; R-type funct7 not 0x00/0x20, or 0x20 with funct3 not 0/5;
//    SLLI funct7!=0; SRLI/SRAI funct7 not 0x00/0x20; inst[1:0]!=11.
//    Illegal bundle still delivered: out_illegal=1, write_en/mem_*/branch/jump=0.
//  - States (SKID_EN=1): EMPTY (out_valid=0), ONE (out_valid=1, skid empty), TWO (both full).
//    EMPTY: accept -> ONE.  ONE: accept & ~fire -> TWO; accept & fire -> ONE; fire only -> EMPTY.
//    TWO: in_ready=0; fire -> skid moves to output -> ONE. Order strictly preserved.
//    in_ready = ~skid_full, registered.
//  - SKID_EN=0: in_ready = ~out_valid | out_ready; states EMPTY/ONE only.
//  - Flush: next cycle out_valid=0, skid empty, state EMPTY; instruction offered in flush cycle is dropped.
//    Flush with out_ready=1 in same cycle: current bundle still counts as fired.
//  - Async rst mid-operation: outputs return to reset values immediately; no bundle survives.
// TESTING
//  - ADDI x1,x0,5 (0x00500093) -> next cycle: rd=1, imm=0x5, alu_op=0, src2_imm=1, write_en=1.
//  - SRAI x2,x1,3 (0x4030D113) -> alu_op=4'hD, imm=0x403, write_en=1; SUB x3,x1,x2 (0x402081B3) -> alu_op=4'h8, src2_imm=0.
//  - LUI x5,0x12345 (0x123452B7) -> imm=0x12345000, lui=1; BEQ x0,x0,-4 (0xFE000EE3) -> branch=1, imm=0xFFFFFFFC, src1_pc=1.
//  - 0xFFFFFFFF and LOAD funct3=7 (0x00007003) -> illegal=1, write_en=0, mem_read=0, out_valid=1.
//  - out_ready=0, stream 3 instrs: 2 accepted, in_ready=0 after second; release -> both emerge in order, third accepted, no loss.
//  - State TWO then flush=1 -> next cycle out_valid=0, in_ready=1; rst pulse mid-stream -> out_valid=0 asynchronously.

Source files
------------

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: valid/ready on both sides, an optional skid entry,
// a synchronous flush for redirects, and an illegal-instruction flag for the trap path.
module decode_stage #(
    parameter int unsigned PC_W    = 32,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_write_en,
    output logic [31:0]     out_immediate,
    output logic [3:0]      out_alu_opcode,
    output logic            out_alu_src2_from_imm,
    output logic            out_alu_src1_from_pc,
    output logic            out_lui_inst,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned ALU_W = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'h0;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'h8;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             write_en;
        logic [XLEN-1:0]  immediate;
        logic [ALU_W-1:0] alu_opcode;
        logic             alu_src2_from_imm;
        logic             alu_src1_from_pc;
        logic             lui_inst;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             jump;
        logic             illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    bundle_t dec;
    logic    legal;
    logic    writes_rd;

    state_t  state;
    state_t  next_state;
    bundle_t out_q;
    bundle_t skid_q;
    logic    in_ready_q;

    logic    accept_c;
    logic    fire_c;
    logic    ld_out_from_in;
    logic    ld_out_from_skid;
    logic    ld_skid;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Instruction decode; an illegal encoding keeps its register fields but loses every side effect.
    always_comb begin
        dec       = '0;
        legal     = 1'b1;
        writes_rd = 1'b0;
        dec.pc    = in_pc;
        dec.rd    = in_inst[11:7];
        dec.rs1   = in_inst[19:15];
        dec.rs2   = in_inst[24:20];
        case (opcode)
            OPC_LUI: begin
                dec.immediate         = imm_u;
                dec.alu_src2_from_imm = 1'b1;
                dec.lui_inst          = 1'b1;
                writes_rd             = 1'b1;
            end
            OPC_AUIPC: begin
                dec.immediate         = imm_u;
                dec.alu_src2_from_imm = 1'b1;
                dec.alu_src1_from_pc  = 1'b1;
                writes_rd             = 1'b1;
            end
            OPC_JAL: begin
                dec.immediate         = imm_j;
                dec.alu_src2_from_imm = 1'b1;
                dec.alu_src1_from_pc  = 1'b1;
                dec.jump              = 1'b1;
                writes_rd             = 1'b1;
            end
            OPC_JALR: begin
                dec.immediate         = imm_i;
                dec.alu_src2_from_imm = 1'b1;
                dec.jump              = 1'b1;
                writes_rd             = 1'b1;
                legal                 = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec.immediate        = imm_b;
                dec.alu_opcode       = ALU_SUB;
                dec.alu_src1_from_pc = 1'b1;
                dec.branch           = 1'b1;
                legal                = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_LOAD: begin
                dec.immediate         = imm_i;
                dec.alu_src2_from_imm = 1'b1;
                dec.mem_read          = 1'b1;
                writes_rd             = 1'b1;
                legal                 = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                dec.immediate         = imm_s;
                dec.alu_src2_from_imm = 1'b1;
                dec.mem_write         = 1'b1;
                legal                 = (funct3 <= 3'b010);
            end
            OPC_OP_IMM: begin
                dec.immediate         = imm_i;
                dec.alu_src2_from_imm = 1'b1;
                writes_rd             = 1'b1;
                // Only the right shifts carry inst[30] into the ALU op; elsewhere it is immediate data.
                dec.alu_opcode        = (funct3 == 3'b101) ? {in_inst[30], funct3} : {1'b0, funct3};
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'h00);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                end
            end
            OPC_OP: begin
                dec.alu_opcode = {in_inst[30], funct3};
                writes_rd      = 1'b1;
                legal          = (funct7 == 7'h00) ||
                                 ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        if (!legal) begin
            dec.immediate         = '0;
            dec.alu_opcode        = ALU_ADD;
            dec.alu_src2_from_imm = 1'b0;
            dec.alu_src1_from_pc  = 1'b0;
            dec.lui_inst          = 1'b0;
            dec.mem_read          = 1'b0;
            dec.mem_write         = 1'b0;
            dec.branch            = 1'b0;
            dec.jump              = 1'b0;
            dec.illegal           = 1'b1;
        end
        dec.write_en = writes_rd && legal && (dec.rd != 5'd0);
    end

    assign accept_c = in_valid && in_ready;
    assign fire_c   = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (accept_c) next_state = S_ONE;
                S_ONE: begin
                    if (accept_c && !fire_c && SKID_EN) begin
                        next_state = S_TWO;
                    end else if (!accept_c && fire_c) begin
                        next_state = S_EMPTY;
                    end
                end
                S_TWO:   if (fire_c) next_state = S_ONE;
                default: next_state = S_EMPTY;
            endcase
        end
    end

    // Output / datapath-control logic.
    always_comb begin
        out_valid        = (state != S_EMPTY);
        in_ready         = SKID_EN ? in_ready_q : (!out_valid || out_ready);
        ld_out_from_in   = 1'b0;
        ld_out_from_skid = 1'b0;
        ld_skid          = 1'b0;
        if (!flush) begin
            case (state)
                S_EMPTY: ld_out_from_in = accept_c;
                S_ONE: begin
                    ld_out_from_in = accept_c && fire_c;
                    ld_skid        = accept_c && !fire_c && SKID_EN;
                end
                S_TWO:   ld_out_from_skid = fire_c;
                default: ld_out_from_in = 1'b0;
            endcase
        end
    end

    // Output and skid registers; in_ready is precomputed from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (next_state != S_TWO);
            if (ld_out_from_in) begin
                out_q <= dec;
            end else if (ld_out_from_skid) begin
                out_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign out_pc                = out_q.pc;
    assign out_rd                = out_q.rd;
    assign out_rs1               = out_q.rs1;
    assign out_rs2               = out_q.rs2;
    assign out_write_en          = out_q.write_en;
    assign out_immediate         = out_q.immediate;
    assign out_alu_opcode        = out_q.alu_opcode;
    assign out_alu_src2_from_imm = out_q.alu_src2_from_imm;
    assign out_alu_src1_from_pc  = out_q.alu_src1_from_pc;
    assign out_lui_inst          = out_q.lui_inst;
    assign out_mem_read          = out_q.mem_read;
    assign out_mem_write         = out_q.mem_write;
    assign out_branch            = out_q.branch;
    assign out_jump              = out_q.jump;
    assign out_illegal           = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus random traffic, checked by a scoreboard
// fed from a reference decoder and drained by an independent output monitor.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        we;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        s2;
        logic        s1;
        logic        lui;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jmp;
        logic        ill;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_write_en;
    logic [31:0] out_immediate;
    logic [3:0]  out_alu_opcode;
    logic        out_alu_src2_from_imm;
    logic        out_alu_src1_from_pc;
    logic        out_lui_inst;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_branch;
    logic        out_jump;
    logic        out_illegal;

    int      errors = 0;
    int      checks = 0;
    int      fires  = 0;
    bundle_t sb[$];
    logic    clear_pending = 1'b0;
    logic    hold_pending  = 1'b0;
    bundle_t held;

    decode_stage #(.PC_W(32), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_write_en(out_write_en), .out_immediate(out_immediate),
        .out_alu_opcode(out_alu_opcode), .out_alu_src2_from_imm(out_alu_src2_from_imm),
        .out_alu_src1_from_pc(out_alu_src1_from_pc), .out_lui_inst(out_lui_inst),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Reference decoder written from the ISA rules with shifts and set membership.
    function automatic bundle_t model(input logic [31:0] i, input logic [31:0] pc);
        bundle_t         b;
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic signed [31:0] s;
        logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
        logic            ok, wr;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25]; s = i;
        imm_i = 32'(s >>> 20);
        imm_s = (imm_i & ~32'h1f) | 32'(i[11:7]);
        imm_b = (32'(s >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        imm_u = i & 32'hFFFF_F000;
        imm_j = (32'(s >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        b = '0;
        b.pc = pc; b.rd = i[11:7]; b.rs1 = i[19:15]; b.rs2 = i[24:20];
        ok = 1'b1; wr = 1'b0;
        case (op)
            7'h37: begin b.imm = imm_u; b.s2 = 1; b.lui = 1; wr = 1; end
            7'h17: begin b.imm = imm_u; b.s2 = 1; b.s1 = 1; wr = 1; end
            7'h6F: begin b.imm = imm_j; b.s2 = 1; b.s1 = 1; b.jmp = 1; wr = 1; end
            7'h67: begin b.imm = imm_i; b.s2 = 1; b.jmp = 1; wr = 1; ok = (f3 == 0); end
            7'h63: begin b.imm = imm_b; b.alu = 4'h8; b.s1 = 1; b.br = 1; ok = !(f3 inside {3'd2, 3'd3}); end
            7'h03: begin b.imm = imm_i; b.s2 = 1; b.mr = 1; wr = 1; ok = !(f3 inside {3'd3, 3'd6, 3'd7}); end
            7'h23: begin b.imm = imm_s; b.s2 = 1; b.mw = 1; ok = (f3 inside {3'd0, 3'd1, 3'd2}); end
            7'h13: begin
                b.imm = imm_i; b.s2 = 1; wr = 1;
                b.alu = (f3 == 3'd5) ? 4'(f3 + (i[30] ? 8 : 0)) : 4'(f3);
                if (f3 == 3'd1) ok = (f7 == 0);
                if (f3 == 3'd5) ok = (f7 inside {7'h00, 7'h20});
            end
            7'h33: begin
                b.alu = 4'(f3 + (i[30] ? 8 : 0)); wr = 1;
                ok = (f7 == 0) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            b.imm = 0; b.mr = 0; b.mw = 0; b.br = 0; b.jmp = 0; b.ill = 1;
        end
        b.we = wr && ok && (b.rd != 0);
        return b;
    endfunction

    // ALU/source selects are not defined for an illegal bundle, so they are not compared there.
    function automatic bundle_t mask(input bundle_t b, input logic ill);
        bundle_t m;
        m = b;
        if (ill) begin
            m.alu = 0; m.s2 = 0; m.s1 = 0; m.lui = 0;
        end
        return m;
    endfunction

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b.pc = out_pc; b.rd = out_rd; b.rs1 = out_rs1; b.rs2 = out_rs2;
        b.we = out_write_en; b.imm = out_immediate; b.alu = out_alu_opcode;
        b.s2 = out_alu_src2_from_imm; b.s1 = out_alu_src1_from_pc; b.lui = out_lui_inst;
        b.mr = out_mem_read; b.mw = out_mem_write; b.br = out_branch; b.jmp = out_jump;
        b.ill = out_illegal;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One cycle of stimulus; accepted non-flushed instructions go to the scoreboard.
    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        if (clear_pending) begin
            sb.delete();
            clear_pending = 1'b0;
        end
        in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
        @(negedge clk);
        if (flush) clear_pending = 1'b1;
        else if (in_valid && in_ready) sb.push_back(model(in_inst, in_pc));
    endtask

    // Output monitor: compares each fired bundle with the scoreboard head and checks stall stability.
    always @(negedge clk) begin
        bundle_t got, exp;
        if (!rst && out_valid) begin
            got = dut_bundle();
            if (hold_pending) begin
                checks++;
                if (got !== held) begin
                    errors++;
                    $display("FAIL hold: got %h expected %h", got, held);
                end
            end
            if (out_ready) begin
                hold_pending = 1'b0;
                fires++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got bundle pc=0x%08h expected none", got.pc);
                end else begin
                    exp = sb.pop_front();
                    if (mask(got, exp.ill) !== mask(exp, exp.ill)) begin
                        errors++;
                        $display("FAIL sb_bundle: got %h expected %h", mask(got, exp.ill), mask(exp, exp.ill));
                    end
                end
            end else begin
                held = got;
                hold_pending = 1'b1;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [11];
        logic [31:0] r;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        r = $urandom;
        if ($urandom_range(0, 9) == 0) return r;
        r[6:0] = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) == 1) r[31:25] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
        return r;
    endfunction

    initial begin
        rst = 1'b1; flush = 0; in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_imm", out_immediate, 0);
        chk("rst_pc", out_pc, 0);
        @(posedge clk); #1; rst = 1'b0;

        drive(1, 32'h00500093, 32'h100, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk("addi_valid", 32'(out_valid), 1);
        chk("addi_rd", 32'(out_rd), 1);
        chk("addi_imm", out_immediate, 5);
        chk("addi_alu", 32'(out_alu_opcode), 0);
        chk("addi_src2", 32'(out_alu_src2_from_imm), 1);
        chk("addi_we", 32'(out_write_en), 1);

        drive(1, 32'h4030D113, 32'h104, 1, 0);
        drive(1, 32'h402081B3, 32'h108, 1, 0);
        chk("srai_alu", 32'(out_alu_opcode), 32'hD);
        chk("srai_imm", out_immediate, 32'h403);
        chk("srai_we", 32'(out_write_en), 1);
        drive(1, 32'h123452B7, 32'h10C, 1, 0);
        chk("sub_alu", 32'(out_alu_opcode), 8);
        chk("sub_src2", 32'(out_alu_src2_from_imm), 0);
        drive(1, 32'hFE000EE3, 32'h110, 1, 0);
        chk("lui_imm", out_immediate, 32'h12345000);
        chk("lui_flag", 32'(out_lui_inst), 1);
        drive(1, 32'hFFFFFFFF, 32'h114, 1, 0);
        chk("beq_branch", 32'(out_branch), 1);
        chk("beq_imm", out_immediate, 32'hFFFFFFFC);
        chk("beq_src1", 32'(out_alu_src1_from_pc), 1);
        drive(1, 32'h00007003, 32'h118, 1, 0);
        chk("ones_illegal", 32'(out_illegal), 1);
        chk("ones_we", 32'(out_write_en), 0);
        drive(0, 0, 0, 1, 0);
        chk("ld7_valid", 32'(out_valid), 1);
        chk("ld7_illegal", 32'(out_illegal), 1);
        chk("ld7_mem_read", 32'(out_mem_read), 0);
        chk("ld7_we", 32'(out_write_en), 0);

        // Backpressure: two entries held, third waits until the output drains.
        drive(1, 32'h00100093, 32'h200, 0, 0);
        chk("bp_ready1", 32'(in_ready), 1);
        drive(1, 32'h00200113, 32'h204, 0, 0);
        chk("bp_ready2", 32'(in_ready), 1);
        drive(1, 32'h00300193, 32'h208, 0, 0);
        chk("bp_full", 32'(in_ready), 0);
        chk("bp_head", out_pc, 32'h200);
        drive(1, 32'h00300193, 32'h208, 1, 0);
        chk("bp_full_fire", 32'(in_ready), 0);
        drive(1, 32'h00300193, 32'h208, 1, 0);
        chk("bp_second", out_pc, 32'h204);
        chk("bp_ready_again", 32'(in_ready), 1);
        drive(0, 0, 0, 1, 0);
        chk("bp_third", out_pc, 32'h208);

        // Flush from the two-entry state, then from one entry with an offered instruction.
        drive(1, 32'h00100093, 32'h300, 0, 0);
        drive(1, 32'h00200113, 32'h304, 0, 0);
        drive(1, 32'h00300193, 32'h308, 0, 1);
        chk("fl_two_ready", 32'(in_ready), 0);
        drive(0, 0, 0, 1, 0);
        chk("fl_valid", 32'(out_valid), 0);
        chk("fl_ready", 32'(in_ready), 1);
        drive(1, 32'h00400213, 32'h30C, 0, 0);
        drive(1, 32'h00500293, 32'h310, 0, 1);
        drive(0, 0, 0, 1, 0);
        chk("fl_one_valid", 32'(out_valid), 0);

        // Asynchronous reset in the middle of a cycle.
        drive(1, 32'h00600313, 32'h400, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("ar_before", 32'(out_valid), 1);
        @(posedge clk); #2; rst = 1'b1; #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_pc", out_pc, 0);
        sb.delete(); in_valid = 0;
        @(posedge clk); #1; rst = 1'b0;

        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 9) < 7, rand_inst(), 32'h1000 + 32'(n) * 4,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
        end
        repeat (4) drive(0, 0, 0, 1, 0);
        chk("drain_sb_empty", 32'(sb.size()), 0);
        chk("drain_valid", 32'(out_valid), 0);
        chk("random_fired", 32'(fires > 300), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
